visaccum_sat: RTL

//  Final-stage visibility accumulator for NSUMS time-interleaved channels. Sums IBITS

---
 rtl/vis_pkg.sv | 27 ++
 rtl/vissat.sv | 28 ++
 rtl/visaccum_sat.sv | 106 ++++++++++
 3 files changed

// File: rtl/vis_pkg.sv
// Shared helpers for the visibility accumulator and readout stages:
// index-width math and representable limits for an OBITS-wide sum.
package vis_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // Channel-index width; a degenerate single-channel case still needs one bit.
  function automatic int abits(input int nsums);
    return (nsums < 2) ? 1 : clog2(nsums);
  endfunction

  function automatic longint lim_max(input int obits, input bit is_signed);
    return is_signed ? (longint'(1) << (obits - 1)) - 1 : (longint'(1) << obits) - 1;
  endfunction

  function automatic longint lim_min(input int obits, input bit is_signed);
    return is_signed ? -(longint'(1) << (obits - 1)) : longint'(0);
  endfunction

endpackage

// File: rtl/vissat.sv
// Combinational (OBITS+1)-bit to OBITS-bit range reduction: clamp or wrap,
// with a flag raised whenever the input lies outside the OBITS range.
module vissat
  import vis_pkg::*;
#(
  parameter int unsigned OBITS    = 8,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [OBITS:0]   i_sum,
  output logic [OBITS-1:0] o_data,
  output logic             o_ovf
);

  localparam logic [OBITS-1:0] MAX_V = OBITS'(lim_max(OBITS, SIGNED));
  localparam logic [OBITS-1:0] MIN_V = OBITS'(lim_min(OBITS, SIGNED));

  // Signed: out of range when the two top bits disagree, and the extra bit
  // then gives the direction. Unsigned: only an upward carry is possible.
  always_comb begin
    o_ovf  = SIGNED ? (i_sum[OBITS] != i_sum[OBITS-1]) : i_sum[OBITS];
    o_data = i_sum[OBITS-1:0];
    if (o_ovf && SATURATE) begin
      o_data = (SIGNED && i_sum[OBITS]) ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/visaccum_sat.sv
// Frame accumulator for NSUMS interleaved visibility channels: per-channel
// sums with sticky overflow, each last-block result emitted two cycles later.
module visaccum_sat
  import vis_pkg::*;
#(
  parameter int unsigned IBITS    = 5,
  parameter int unsigned OBITS    = 8,
  parameter int unsigned NSUMS    = 4,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             first_i,
  input  logic             last_i,
  input  logic [IBITS-1:0] data_i,
  output logic             valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic [OBITS-1:0] data_o,
  output logic             ovf_o
);

  localparam int ABITS = abits(NSUMS);
  localparam logic [ABITS-1:0] LAST_SEL = ABITS'(NSUMS - 1);

  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic             ovf;
    logic [OBITS-1:0] data;
  } beat_t;

  logic [ABITS-1:0] r_sel;
  logic             r_prev_first;
  logic [OBITS-1:0] r_acc [NSUMS];
  logic [NSUMS-1:0] r_ovf;
  beat_t            r_p1, r_p2;

  logic [ABITS-1:0] w_sel;
  logic [OBITS:0]   w_ext_data, w_ext_acc, w_sum;
  logic [OBITS-1:0] w_sat, w_new_acc;
  logic             w_sat_ovf, w_new_ovf;
  beat_t            w_p0;

  // NOTE: always_comb assigns every output first so no path can infer a latch.
  always_comb begin
    w_sel      = (first_i && !r_prev_first) ? '0 : r_sel;
    w_ext_data = {{(OBITS + 1 - IBITS){SIGNED && data_i[IBITS-1]}}, data_i};
    w_ext_acc  = {SIGNED && r_acc[w_sel][OBITS-1], r_acc[w_sel]};
    w_sum      = w_ext_acc + w_ext_data;
    w_new_acc  = first_i ? w_ext_data[OBITS-1:0] : w_sat;
    w_new_ovf  = first_i ? 1'b0 : (r_ovf[w_sel] | w_sat_ovf);
    w_p0       = '0;
    if (valid_i && last_i) begin
      w_p0.valid = 1'b1;
      w_p0.first = (w_sel == '0);
      w_p0.last  = (w_sel == LAST_SEL);
      w_p0.ovf   = w_new_ovf;
      w_p0.data  = w_new_acc;
    end
  end

  vissat #(
    .OBITS    (OBITS),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_vissat (
    .i_sum  (w_sum),
    .o_data (w_sat),
    .o_ovf  (w_sat_ovf)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sel        <= '0;
      r_prev_first <= 1'b0;
      r_ovf        <= '0;
      r_p1         <= '0;
      r_p2         <= '0;
    end else begin
      r_p1 <= w_p0;
      r_p2 <= r_p1;
      if (valid_i) begin
        r_sel        <= w_sel + 1'b1;
        r_prev_first <= first_i;
        r_ovf[w_sel] <= w_new_ovf;
      end
    end
  end

  // NOTE: the sum array is not reset; every frame loads it on its first block.
  always_ff @(posedge clock) begin
    if (valid_i) r_acc[w_sel] <= w_new_acc;
  end

  assign valid_o = r_p2.valid;
  assign first_o = r_p2.first;
  assign last_o  = r_p2.last;
  assign ovf_o   = r_p2.ovf;
  assign data_o  = r_p2.data;

endmodule
